// File: rtl/approx_mac_pkg.sv
// Shared definitions for the approximate-multiplier MAC accumulator:
// FSM state encoding, default sizing and the multiplier product width.
package approx_mac_pkg;

  // Product width delivered by the upstream 8x8 approximate multiplier.
  localparam int PROD_W        = 16;

  // Default sizing of the accumulator datapath.
  localparam int ACC_W_DEF     = 24;
  localparam int CNT_W_DEF     = 8;
  localparam int MAX_TERMS_DEF = 255;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : approx_mac_pkg

// File: rtl/approx_mac_acc_if.sv
// Product-in / result-out handshake bundle of the MAC accumulator.
// master = producer of beats and consumer of results; slave = the accumulator.
interface approx_mac_acc_if #(
  parameter int ACC_W = approx_mac_pkg::ACC_W_DEF,
  parameter int CNT_W = approx_mac_pkg::CNT_W_DEF
);
  import approx_mac_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic              out_trunc;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
  );

endinterface : approx_mac_acc_if

// File: rtl/approx_mac_acc_sat_add.sv
// Combinational ACC_W-bit saturating adder: accumulator plus a zero-extended
// PROD_W-bit product. ovf_o flags that the true sum did not fit and the
// result was clamped to all ones.
module acc_sat_add
  import approx_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] opnd_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  // One extra bit holds the carry out of the unsigned addition.
  logic [ACC_W:0] full_s;

  // Add with carry, then clamp to the largest representable value on carry out.
  always_comb begin
    full_s = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, opnd_i};
    if (full_s[ACC_W]) begin
      sum_o = {ACC_W{1'b1}};
      ovf_o = 1'b1;
    end else begin
      sum_o = full_s[ACC_W-1:0];
      ovf_o = 1'b0;
    end
  end

endmodule : acc_sat_add

// File: rtl/approx_mac_acc.sv
// Streaming saturating dot-product accumulator. Sums one 16-bit product per
// accepted beat until in_last or the term limit, then presents the result
// (sum, term count, saturation and truncation flags) on a valid/ready port.
// At least one bubble cycle separates vectors because the DONE state never
// accepts input.
module approx_mac_acc
  import approx_mac_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  approx_mac_acc_if.slave  bus
);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_sat_q;
  logic             out_trunc_q;

  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_d;
  logic             ovf_s;
  logic             accept_s;
  logic             end_s;

  // Saturating add of the incoming product onto the running sum.
  acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_i  (acc_q),
    .opnd_i (bus.in_prod),
    .sum_o  (acc_d),
    .ovf_o  (ovf_s)
  );

  // Beat acceptance and the end-of-vector decision for the current beat.
  always_comb begin
    accept_s = (state_q == ST_ACC) && bus.in_valid;
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    sat_d    = sat_q | ovf_s;
    end_s    = accept_s && (bus.in_last || (cnt_d == CNT_W'(MAX_TERMS)));
  end

  // Controller FSM with accumulator, counter, sticky flag and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
      out_sat_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_ACC;
        end
        ST_ACC: begin
          if (end_s) begin
            // Publish the result including this beat and start a fresh vector.
            out_sum_q   <= acc_d;
            out_count_q <= cnt_d;
            out_sat_q   <= sat_d;
            out_trunc_q <= ~bus.in_last;
            out_valid_q <= 1'b1;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            sat_q       <= 1'b0;
            state_q     <= ST_DONE;
          end else if (accept_s) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
          end else begin
            acc_q <= acc_q;
          end
        end
        ST_DONE: begin
          // Result fields stay as they are after the handshake; only valid drops.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_trunc = out_trunc_q;

endmodule : approx_mac_acc

// File: tb/tb_approx_mac_acc.sv
// Directed self-checking bench for approx_mac_acc. Three instances:
// 0 = default sizing, 1 = ACC_W 17 (saturation), 2 = MAX_TERMS 4 (truncation).
module tb_approx_mac_acc;

  logic clk;
  logic rst;

  logic        v    [3];
  logic [15:0] p    [3];
  logic        l    [3];
  logic        ordy [3];

  logic        rdy  [3];
  logic        ov   [3];
  logic [31:0] sum  [3];
  logic [31:0] cnt  [3];
  logic        sat  [3];
  logic        trc  [3];

  int checks;
  int errors;

  approx_mac_acc_if #(.ACC_W(24), .CNT_W(8)) if0 ();
  approx_mac_acc_if #(.ACC_W(17), .CNT_W(8)) if1 ();
  approx_mac_acc_if #(.ACC_W(24), .CNT_W(8)) if2 ();

  approx_mac_acc #(.ACC_W(24), .CNT_W(8), .MAX_TERMS(255)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  approx_mac_acc #(.ACC_W(17), .CNT_W(8), .MAX_TERMS(255)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  approx_mac_acc #(.ACC_W(24), .CNT_W(8), .MAX_TERMS(4))   u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.in_valid = v[0];  assign if0.in_prod = p[0];  assign if0.in_last = l[0];  assign if0.out_ready = ordy[0];
  assign if1.in_valid = v[1];  assign if1.in_prod = p[1];  assign if1.in_last = l[1];  assign if1.out_ready = ordy[1];
  assign if2.in_valid = v[2];  assign if2.in_prod = p[2];  assign if2.in_last = l[2];  assign if2.out_ready = ordy[2];

  assign rdy[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign sum[0] = 32'(if0.out_sum);
  assign cnt[0] = 32'(if0.out_count);  assign sat[0] = if0.out_sat;  assign trc[0] = if0.out_trunc;
  assign rdy[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign sum[1] = 32'(if1.out_sum);
  assign cnt[1] = 32'(if1.out_count);  assign sat[1] = if1.out_sat;  assign trc[1] = if1.out_trunc;
  assign rdy[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign sum[2] = 32'(if2.out_sum);
  assign cnt[2] = 32'(if2.out_count);  assign sat[2] = if2.out_sat;  assign trc[2] = if2.out_trunc;

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one beat on instance idx (called at a falling edge) and wait,
  // bounded, for the rising edge that accepts it; returns at a falling edge.
  task automatic beat(input int idx, input logic [15:0] prod, input logic last);
    bit got;
    got     = 1'b0;
    v[idx]  = 1'b1;
    p[idx]  = prod;
    l[idx]  = last;
    for (int k = 0; k < 50 && !got; k++) begin
      if (rdy[idx]) got = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    v[idx] = 1'b0;
    chk("beat_accept", {31'd0, got}, 32'd1);
  endtask

  // Check the full result tuple of instance idx.
  task automatic chk_res(input int idx, input logic [31:0] e_sum, input logic [31:0] e_cnt,
                         input logic e_sat, input logic e_trc);
    chk("res_valid", {31'd0, ov[idx]},  32'd1);
    chk("res_sum",   sum[idx],          e_sum);
    chk("res_count", cnt[idx],          e_cnt);
    chk("res_sat",   {31'd0, sat[idx]}, {31'd0, e_sat});
    chk("res_trunc", {31'd0, trc[idx]}, {31'd0, e_trc});
  endtask

  // Advance one full clock, ending at a falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed stimulus sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; p[i] = 16'd0; l[i] = 1'b0; ordy[i] = 1'b1;
    end

    // 1: reset held three cycles, then released.
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready",  {31'd0, rdy[0]}, 32'd0);
      chk("rst_out_valid", {31'd0, ov[0]},  32'd0);
    end
    rst = 1'b0;
    chk("idle_in_ready", {31'd0, rdy[0]}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) chk("acc_in_ready", {31'd0, rdy[i]}, 32'd1);
    chk("init_valid", {31'd0, ov[0]},  32'd0);
    chk("init_sum",   sum[0],          32'd0);
    chk("init_count", cnt[0],          32'd0);
    chk("init_sat",   {31'd0, sat[0]}, 32'd0);
    chk("init_trunc", {31'd0, trc[0]}, 32'd0);

    // 2: three-term vector, result one cycle after the last accept.
    beat(0, 16'd100, 1'b0);
    beat(0, 16'd200, 1'b0);
    chk("mid_valid", {31'd0, ov[0]}, 32'd0);
    beat(0, 16'd300, 1'b1);
    chk_res(0, 32'd600, 32'd3, 1'b0, 1'b0);
    chk("done_in_ready", {31'd0, rdy[0]}, 32'd0);
    tick();
    chk("drain_valid", {31'd0, ov[0]}, 32'd0);
    chk("hold_sum",    sum[0],         32'd600);

    // 3: back-pressure with in_valid held high in DONE.
    ordy[0] = 1'b0;
    beat(0, 16'd100, 1'b0);
    beat(0, 16'd200, 1'b0);
    beat(0, 16'd300, 1'b1);
    v[0] = 1'b1; p[0] = 16'd7; l[0] = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid",    {31'd0, ov[0]},  32'd1);
      chk("bp_sum",      sum[0],          32'd600);
      chk("bp_in_ready", {31'd0, rdy[0]}, 32'd0);
    end
    ordy[0] = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, ov[0]},  32'd0);
    chk("bp_release_ready", {31'd0, rdy[0]}, 32'd1);
    tick();
    beat(0, 16'd1, 1'b1);
    chk_res(0, 32'd8, 32'd2, 1'b0, 1'b0);

    // 4: saturation at ACC_W 17, then a clean vector clears the flag.
    beat(1, 16'd65535, 1'b0);
    beat(1, 16'd65535, 1'b0);
    beat(1, 16'd65535, 1'b1);
    chk_res(1, 32'd131071, 32'd3, 1'b1, 1'b0);
    beat(1, 16'd5, 1'b1);
    chk_res(1, 32'd5, 32'd1, 1'b0, 1'b0);

    // 5: MAX_TERMS 4 truncates a six-beat vector.
    for (int k = 0; k < 4; k++) beat(2, 16'd1, 1'b0);
    chk_res(2, 32'd4, 32'd4, 1'b0, 1'b1);
    beat(2, 16'd1, 1'b0);
    beat(2, 16'd1, 1'b1);
    chk_res(2, 32'd2, 32'd2, 1'b0, 1'b0);
    // in_last on the limiting beat is a normal end, not a truncation.
    for (int k = 0; k < 3; k++) beat(2, 16'd3, 1'b0);
    beat(2, 16'd3, 1'b1);
    chk_res(2, 32'd12, 32'd4, 1'b0, 1'b0);

    // 6: asynchronous reset mid-vector discards the partial sum.
    beat(0, 16'd9, 1'b0);
    beat(0, 16'd9, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",    {31'd0, ov[0]},  32'd0);
    chk("arst_sum",      sum[0],          32'd0);
    chk("arst_count",    cnt[0],          32'd0);
    chk("arst_sat",      {31'd0, sat[1]}, 32'd0);
    chk("arst_trunc",    {31'd0, trc[0]}, 32'd0);
    chk("arst_in_ready", {31'd0, rdy[0]}, 32'd0);
    chk("arst_count2",   cnt[2],          32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    beat(0, 16'd5, 1'b1);
    chk_res(0, 32'd5, 32'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_approx_mac_acc
